// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding, control
// bundle layout and the sizing helper for the stall/flush down-counter.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_MEM_WAIT = 2'd3
  } hz_state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic pipe_en;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_OFF    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam hz_ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam hz_ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  // if_id_en stays high during a flush; the synchronous clear takes precedence.
  localparam hz_ctrl_t CTRL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  function automatic int cnt_bits(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle. Pipeline side is the master (drives
// hazard sources, consumes controls); the controller is the slave.
interface pipeline_hazard_ctrl_if;

  logic [pipeline_hazard_ctrl_pkg::REG_W-1:0] id_rs1;
  logic [pipeline_hazard_ctrl_pkg::REG_W-1:0] id_rs2;
  logic                                       id_use_rs1;
  logic                                       id_use_rs2;
  logic [pipeline_hazard_ctrl_pkg::REG_W-1:0] ex_rd;
  logic                                       ex_mem_read;
  logic                                       ex_br_taken;
  logic                                       dmem_req;
  logic                                       dmem_ready;

  logic       pc_en;
  logic       if_id_en;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       pipe_en;
  logic [1:0] ctrl_state;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_br_taken, dmem_req, dmem_ready,
    input  pc_en, if_id_en, if_id_flush, id_ex_flush, pipe_en, ctrl_state
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_br_taken, dmem_req, dmem_ready,
    output pc_en, if_id_en, if_id_flush, id_ex_flush, pipe_en, ctrl_state
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_perf_cnt.sv
// hazard_perf_cnt: saturating event counter used for the optional hazard
// performance statistics.
module hazard_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline (PC, IF/ID, ID/EX, EX/MEM).
// Optional perf counters (stall/flush/memwait) are built when HAZ_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES   = 1,
  parameter int BRANCH_FLUSH_CYCLES = 1
`ifdef HAZ_PERF_CNT_EN
  , parameter int CNT_W             = 32
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  hz
`ifdef HAZ_PERF_CNT_EN
  , output logic [CNT_W-1:0]     stall_cnt
  , output logic [CNT_W-1:0]     flush_cnt
  , output logic [CNT_W-1:0]     memwait_cnt
`endif
);

  localparam int CNT_BITS = cnt_bits(LOAD_STALL_CYCLES, BRANCH_FLUSH_CYCLES);
  localparam logic [CNT_BITS-1:0] LSC_RELOAD =
    CNT_BITS'((LOAD_STALL_CYCLES > 1) ? LOAD_STALL_CYCLES - 2 : 0);
  localparam logic [CNT_BITS-1:0] BFC_RELOAD =
    CNT_BITS'((BRANCH_FLUSH_CYCLES > 1) ? BRANCH_FLUSH_CYCLES - 2 : 0);

  hz_state_e           state_q, state_d;
  hz_state_e           saved_q, saved_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  hz_ctrl_t            ctrl;
  logic                mem_wait;
  logic                lu_hazard;

  assign mem_wait  = hz.dmem_req & ~hz.dmem_ready;
  assign lu_hazard = hz.ex_mem_read && (hz.ex_rd != '0) &&
                     ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                      (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

  // Mealy decode: controls follow state, cnt and inputs in the same cycle.
  always_comb begin
    ctrl    = CTRL_OFF;
    state_d = state_q;
    saved_d = saved_q;
    cnt_d   = cnt_q;
    if (mem_wait) begin
      ctrl = CTRL_OFF;
      if (state_q != ST_MEM_WAIT) begin
        saved_d = state_q;
        state_d = ST_MEM_WAIT;
      end
    end else begin
      unique case (state_q)
        ST_RUN, ST_LU_STALL: begin
          if (hz.ex_br_taken) begin
            // Wrong-path instructions are discarded, so a pending load-use stall is dropped.
            ctrl = CTRL_FLUSH;
            if (BRANCH_FLUSH_CYCLES > 1) begin
              state_d = ST_REDIRECT;
              cnt_d   = BFC_RELOAD;
            end else begin
              state_d = ST_RUN;
            end
          end else if (state_q == ST_LU_STALL) begin
            ctrl = CTRL_STALL;
            if (cnt_q == '0) state_d = ST_RUN;
            else             cnt_d   = cnt_q - 1'b1;
          end else if (lu_hazard) begin
            ctrl = CTRL_STALL;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d = ST_LU_STALL;
              cnt_d   = LSC_RELOAD;
            end
          end else begin
            ctrl = CTRL_RUN;
          end
        end
        ST_REDIRECT: begin
          ctrl = CTRL_FLUSH;
          if (cnt_q == '0) state_d = ST_RUN;
          else             cnt_d   = cnt_q - 1'b1;
        end
        ST_MEM_WAIT: begin
          // Access completes this cycle; hold the freeze once more, then resume.
          ctrl    = CTRL_OFF;
          state_d = saved_q;
        end
        default: begin
          ctrl    = CTRL_OFF;
          state_d = ST_RUN;
        end
      endcase
    end
    if (rst) ctrl = CTRL_OFF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      saved_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz.pc_en       = ctrl.pc_en;
  assign hz.if_id_en    = ctrl.if_id_en;
  assign hz.if_id_flush = ctrl.if_id_flush;
  assign hz.id_ex_flush = ctrl.id_ex_flush;
  assign hz.pipe_en     = ctrl.pipe_en;
  assign hz.ctrl_state  = rst ? ST_RUN : state_q;

`ifdef HAZ_PERF_CNT_EN
  hazard_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (~ctrl.pc_en & ~mem_wait & ~rst),
    .cnt_o (stall_cnt)
  );

  hazard_perf_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (ctrl.if_id_flush),
    .cnt_o (flush_cnt)
  );

  hazard_perf_cnt #(.W(CNT_W)) u_memwait_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (mem_wait & ~rst),
    .cnt_o (memwait_cnt)
  );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with LOAD_STALL_CYCLES=2, BRANCH_FLUSH_CYCLES=2.
// Inputs change 1ns after posedge; Mealy outputs are sampled on the negedge.
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  // Output vector order: {pc_en, if_id_en, if_id_flush, id_ex_flush, pipe_en}
  localparam logic [4:0] V_OFF   = 5'b00000;
  localparam logic [4:0] V_RUN   = 5'b11001;
  localparam logic [4:0] V_STALL = 5'b00011;
  localparam logic [4:0] V_BR    = 5'b10111;
  localparam logic [4:0] M_ALL   = 5'b11111;
  localparam logic [4:0] M_BR    = 5'b10111; // if_id_en is don't-care while flushing

  pipeline_hazard_ctrl_if hz();

`ifdef HAZ_PERF_CNT_EN
  logic [3:0] stall_cnt, flush_cnt, memwait_cnt;
  pipeline_hazard_ctrl #(
    .LOAD_STALL_CYCLES(2), .BRANCH_FLUSH_CYCLES(2), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .hz(hz),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt)
  );
`else
  pipeline_hazard_ctrl #(
    .LOAD_STALL_CYCLES(2), .BRANCH_FLUSH_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .hz(hz)
  );
`endif

  logic [4:0] got;
  assign got = {hz.pc_en, hz.if_id_en, hz.if_id_flush, hz.id_ex_flush, hz.pipe_en};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hz.id_rs1      = '0;
    hz.id_rs2      = '0;
    hz.id_use_rs1  = 1'b0;
    hz.id_use_rs2  = 1'b0;
    hz.ex_rd       = '0;
    hz.ex_mem_read = 1'b0;
    hz.ex_br_taken = 1'b0;
    hz.dmem_req    = 1'b0;
    hz.dmem_ready  = 1'b0;
  endtask

  task automatic set_load_use_rs2(input logic [4:0] rd, input logic [4:0] rs2, input logic use2);
    hz.ex_mem_read = 1'b1;
    hz.ex_rd       = rd;
    hz.id_rs2      = rs2;
    hz.id_use_rs2  = use2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    #2;
    checks++;
    if (got !== V_OFF || hz.ctrl_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_outputs: got ctrl=%b state=%0d exp ctrl=%b state=0", got, hz.ctrl_state, V_OFF);
    end
    set_load_use_rs2(5'd5, 5'd5, 1'b1);
    hz.ex_br_taken = 1'b1;
    #1;
    checks++;
    if (got !== V_OFF) begin
      failures++;
      $display("FAIL reset_inputs_masked: got ctrl=%b exp ctrl=%b", got, V_OFF);
    end
    tick();
    tick();
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (got !== V_RUN || hz.ctrl_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_release_run: got ctrl=%b state=%0d exp ctrl=%b state=0", got, hz.ctrl_state, V_RUN);
    end
    tick();
  endtask

  task automatic test_load_use();
    set_load_use_rs2(5'd5, 5'd5, 1'b1);
    @(negedge clk);
    checks++;
    if (got !== V_STALL || hz.ctrl_state !== 2'd0) begin
      failures++;
      $display("FAIL lu_stall_c1: got ctrl=%b state=%0d exp ctrl=%b state=0", got, hz.ctrl_state, V_STALL);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (got !== V_STALL || hz.ctrl_state !== 2'd1) begin
      failures++;
      $display("FAIL lu_stall_c2: got ctrl=%b state=%0d exp ctrl=%b state=1", got, hz.ctrl_state, V_STALL);
    end
    tick();
    @(negedge clk);
    checks++;
    if (got !== V_RUN || hz.ctrl_state !== 2'd0) begin
      failures++;
      $display("FAIL lu_after_run: got ctrl=%b state=%0d exp ctrl=%b state=0", got, hz.ctrl_state, V_RUN);
    end
    tick();
  endtask

  task automatic test_no_hazard();
    set_load_use_rs2(5'd0, 5'd0, 1'b1);
    @(negedge clk);
    checks++;
    if (got !== V_RUN || hz.ctrl_state !== 2'd0) begin
      failures++;
      $display("FAIL nohz_rd0: got ctrl=%b state=%0d exp ctrl=%b state=0", got, hz.ctrl_state, V_RUN);
    end
    tick();
    set_load_use_rs2(5'd5, 5'd5, 1'b0);
    @(negedge clk);
    checks++;
    if (got !== V_RUN || hz.ctrl_state !== 2'd0) begin
      failures++;
      $display("FAIL nohz_unused_rs2: got ctrl=%b state=%0d exp ctrl=%b state=0", got, hz.ctrl_state, V_RUN);
    end
    tick();
    set_load_use_rs2(5'd7, 5'd7, 1'b1);
    hz.ex_mem_read = 1'b0;
    @(negedge clk);
    checks++;
    if (got !== V_RUN) begin
      failures++;
      $display("FAIL nohz_not_load: got ctrl=%b exp ctrl=%b", got, V_RUN);
    end
    tick();
    clear_inputs();
    hz.ex_mem_read = 1'b1;
    hz.ex_rd       = 5'd9;
    hz.id_rs1      = 5'd9;
    hz.id_use_rs1  = 1'b1;
    hz.id_rs2      = 5'd3;
    @(negedge clk);
    checks++;
    if (got !== V_STALL || hz.ctrl_state !== 2'd0) begin
      failures++;
      $display("FAIL lu_rs1_hit: got ctrl=%b state=%0d exp ctrl=%b state=0", got, hz.ctrl_state, V_STALL);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (got !== V_STALL || hz.ctrl_state !== 2'd1) begin
      failures++;
      $display("FAIL lu_rs1_c2: got ctrl=%b state=%0d exp ctrl=%b state=1", got, hz.ctrl_state, V_STALL);
    end
    tick();
  endtask

  task automatic test_branch();
    set_load_use_rs2(5'd5, 5'd5, 1'b1);
    hz.ex_br_taken = 1'b1;
    @(negedge clk);
    checks++;
    if ((got & M_BR) !== V_BR || hz.ctrl_state !== 2'd0) begin
      failures++;
      $display("FAIL br_c1: got ctrl=%b state=%0d exp ctrl=%b state=0", got, hz.ctrl_state, V_BR);
    end
    tick();
    clear_inputs();
    hz.ex_br_taken = 1'b1;
    @(negedge clk);
    checks++;
    if ((got & M_BR) !== V_BR || hz.ctrl_state !== 2'd2) begin
      failures++;
      $display("FAIL br_c2_redirect: got ctrl=%b state=%0d exp ctrl=%b state=2", got, hz.ctrl_state, V_BR);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (got !== V_RUN || hz.ctrl_state !== 2'd0) begin
      failures++;
      $display("FAIL br_after_run: got ctrl=%b state=%0d exp ctrl=%b state=0", got, hz.ctrl_state, V_RUN);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    logic [4:0] exp_v [7];
    logic [1:0] exp_s [7];
    logic [4:0] exp_m [7];
    exp_v = '{V_BR,  V_OFF, V_OFF, V_OFF, V_OFF, V_BR,  V_RUN};
    exp_s = '{2'd0,  2'd2,  2'd3,  2'd3,  2'd3,  2'd2,  2'd0};
    exp_m = '{M_BR,  M_ALL, M_ALL, M_ALL, M_ALL, M_BR,  M_ALL};
    for (int i = 0; i < 7; i++) begin
      clear_inputs();
      case (i)
        0: hz.ex_br_taken = 1'b1;
        1: hz.dmem_req = 1'b1;
        2: begin
          hz.dmem_req = 1'b1;
          hz.ex_br_taken = 1'b1;
          set_load_use_rs2(5'd5, 5'd5, 1'b1);
        end
        3: hz.dmem_req = 1'b1;
        4: begin hz.dmem_req = 1'b1; hz.dmem_ready = 1'b1; end
        default: ;
      endcase
      @(negedge clk);
      checks++;
      if ((got & exp_m[i]) !== exp_v[i] || hz.ctrl_state !== exp_s[i]) begin
        failures++;
        $display("FAIL memwait_c%0d: got ctrl=%b state=%0d exp ctrl=%b state=%0d",
                 i, got, hz.ctrl_state, exp_v[i], exp_s[i]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_stall();
    clear_inputs();
    set_load_use_rs2(5'd12, 5'd12, 1'b1);
    @(negedge clk);
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (got !== V_STALL || hz.ctrl_state !== 2'd1) begin
      failures++;
      $display("FAIL rstmid_pre: got ctrl=%b state=%0d exp ctrl=%b state=1", got, hz.ctrl_state, V_STALL);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (got !== V_OFF || hz.ctrl_state !== 2'd0) begin
      failures++;
      $display("FAIL rstmid_async: got ctrl=%b state=%0d exp ctrl=%b state=0", got, hz.ctrl_state, V_OFF);
    end
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (got !== V_RUN || hz.ctrl_state !== 2'd0) begin
      failures++;
      $display("FAIL rstmid_run: got ctrl=%b state=%0d exp ctrl=%b state=0", got, hz.ctrl_state, V_RUN);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    // Branch straight after a completed memory wait that began in RUN.
    clear_inputs();
    hz.dmem_req = 1'b1;
    @(negedge clk);
    tick();
    hz.dmem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (got !== V_OFF || hz.ctrl_state !== 2'd3) begin
      failures++;
      $display("FAIL b2b_wait_done: got ctrl=%b state=%0d exp ctrl=%b state=3", got, hz.ctrl_state, V_OFF);
    end
    tick();
    clear_inputs();
    hz.ex_br_taken = 1'b1;
    @(negedge clk);
    checks++;
    if ((got & M_BR) !== V_BR || hz.ctrl_state !== 2'd0) begin
      failures++;
      $display("FAIL b2b_branch: got ctrl=%b state=%0d exp ctrl=%b state=0", got, hz.ctrl_state, V_BR);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    tick();
  endtask

`ifdef HAZ_PERF_CNT_EN
  task automatic test_perf_sat();
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (stall_cnt !== 4'd0) begin
      failures++;
      $display("FAIL perf_reset: got stall_cnt=%0d exp 0", stall_cnt);
    end
    tick();
    rst = 1'b0;
    set_load_use_rs2(5'd4, 5'd4, 1'b1);
    for (int i = 0; i < 20; i++) tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (stall_cnt !== 4'd15 || flush_cnt !== 4'd0 || memwait_cnt !== 4'd0) begin
      failures++;
      $display("FAIL perf_sat: got stall=%0d flush=%0d memwait=%0d exp 15/0/0",
               stall_cnt, flush_cnt, memwait_cnt);
    end
    tick();
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch();
    test_mem_wait();
    test_reset_mid_stall();
    test_back_to_back();
`ifdef HAZ_PERF_CNT_EN
    test_perf_sat();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
